// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants used by the execute-stage blocks.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

endpackage

// File: rtl/operand_fwd_sel.sv
// Forward select for one source operand: x0 -> 0, then MEM, then WB, else the default value.
module operand_fwd_sel #(
    parameter int XLEN      = cpu_pkg::XLEN,
    parameter int REG_IDX_W = cpu_pkg::REG_IDX_W
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      dflt,
    input  logic                 mem_wr_en,
    input  logic [REG_IDX_W-1:0] mem_wr_rd,
    input  logic [XLEN-1:0]      mem_wr_data,
    input  logic                 wb_wr_en,
    input  logic [REG_IDX_W-1:0] wb_wr_rd,
    input  logic [XLEN-1:0]      wb_wr_data,
    output logic [XLEN-1:0]      value
);

    always_comb begin
        value = dflt;
        if (idx == '0) begin
            value = '0;
        end else if (mem_wr_en && (mem_wr_rd == idx)) begin
            value = mem_wr_data;
        end else if (wb_wr_en && (wb_wr_rd == idx)) begin
            value = wb_wr_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand register feeding the execute-stage add/sub unit.
// Define EX_OPERAND_FWD_EN to enable MEM/WB forwarding and refresh of a held entry.
module ex_operand_stage #(
    parameter int XLEN      = cpu_pkg::XLEN,
    parameter int REG_IDX_W = cpu_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]      in_rs1_val,
    input  logic [XLEN-1:0]      in_rs2_val,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_use_imm,
    input  logic                 in_sub,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 mem_wr_en,
    input  logic [REG_IDX_W-1:0] mem_wr_rd,
    input  logic [XLEN-1:0]      mem_wr_data,
    input  logic                 wb_wr_en,
    input  logic [REG_IDX_W-1:0] wb_wr_rd,
    input  logic [XLEN-1:0]      wb_wr_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic                 out_sub,
    output logic [REG_IDX_W-1:0] out_rd
);

    logic            capture;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b_reg;

    assign in_ready = ~out_valid | out_ready;
    assign capture  = in_valid & in_ready & ~flush;

`ifdef EX_OPERAND_FWD_EN
    logic [REG_IDX_W-1:0] rs1_q;
    logic [REG_IDX_W-1:0] rs2_q;
    logic                 use_imm_q;
    logic [XLEN-1:0]      ref_a;
    logic [XLEN-1:0]      ref_b;

    operand_fwd_sel #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_cap_rs1 (
        .idx(in_rs1_idx), .dflt(in_rs1_val),
        .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_rd(wb_wr_rd), .wb_wr_data(wb_wr_data),
        .value(cap_a)
    );

    operand_fwd_sel #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_cap_rs2 (
        .idx(in_rs2_idx), .dflt(in_rs2_val),
        .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_rd(wb_wr_rd), .wb_wr_data(wb_wr_data),
        .value(cap_b_reg)
    );

    // Refresh path: the stored operand is the default, so a miss keeps it unchanged.
    operand_fwd_sel #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_ref_rs1 (
        .idx(rs1_q), .dflt(out_a),
        .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_rd(wb_wr_rd), .wb_wr_data(wb_wr_data),
        .value(ref_a)
    );

    operand_fwd_sel #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_ref_rs2 (
        .idx(rs2_q), .dflt(out_b),
        .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_rd(wb_wr_rd), .wb_wr_data(wb_wr_data),
        .value(ref_b)
    );
`else
    logic unused_fwd_ports;

    assign cap_a            = in_rs1_val;
    assign cap_b_reg        = in_rs2_val;
    assign unused_fwd_ports = ^{in_rs1_idx, in_rs2_idx, mem_wr_en, mem_wr_rd, mem_wr_data,
                                wb_wr_en, wb_wr_rd, wb_wr_data};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sub   <= 1'b0;
            out_rd    <= '0;
`ifdef EX_OPERAND_FWD_EN
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_a     <= cap_a;
            out_b     <= in_use_imm ? in_imm : cap_b_reg;
            out_sub   <= in_sub & ~in_use_imm;
            out_rd    <= in_rd;
`ifdef EX_OPERAND_FWD_EN
            rs1_q     <= in_rs1_idx;
            rs2_q     <= in_rs2_idx;
            use_imm_q <= in_use_imm;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
`ifdef EX_OPERAND_FWD_EN
            out_a <= ref_a;
            if (!use_imm_q) begin
                out_b <= ref_b;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized self-checking bench for ex_operand_stage with a behavioural entry model.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, in_valid, in_ready, in_use_imm, in_sub;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, out_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        mem_wr_en, wb_wr_en;
    logic [4:0]  mem_wr_rd, wb_wr_rd;
    logic [31:0] mem_wr_data, wb_wr_data;
    logic        out_valid, out_ready, out_sub;
    logic [31:0] out_a, out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sub(in_sub), .in_rd(in_rd),
        .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_rd(wb_wr_rd), .wb_wr_data(wb_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sub(out_sub), .out_rd(out_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view of the single entry the stage holds.
    typedef struct packed {
        bit          v;
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          imm;
    } entry_t;

    entry_t m = '0;
    entry_t n;

    // Value a source register should read right now, given the in-flight MEM/WB results.
    function automatic logic [31:0] src_value(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD_ON && idx == 5'd0) return 32'd0;
        if (FWD_ON && mem_wr_en && mem_wr_rd == idx) return mem_wr_data;
        if (FWD_ON && wb_wr_en && wb_wr_rd == idx) return wb_wr_data;
        return rf;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
        end else begin
            n = m;
            if (flush) begin
                n.v = 1'b0;
            end else if (in_valid && (!m.v || out_ready)) begin
                n.v   = 1'b1;
                n.a   = src_value(in_rs1_idx, in_rs1_val);
                n.b   = in_use_imm ? in_imm : src_value(in_rs2_idx, in_rs2_val);
                n.sub = in_sub && !in_use_imm;
                n.rd  = in_rd;
                n.rs1 = in_rs1_idx;
                n.rs2 = in_rs2_idx;
                n.imm = in_use_imm;
            end else if (out_ready) begin
                n.v = 1'b0;
            end else if (m.v) begin
                n.a = src_value(m.rs1, m.a);
                if (!m.imm) n.b = src_value(m.rs2, m.b);
            end
            m <= n;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(out_valid), 32'(m.v));
        chk("model_in_ready", 32'(in_ready), 32'(!m.v || out_ready));
        if (rst || m.v) begin
            chk("model_a", out_a, m.a);
            chk("model_b", out_b, m.b);
            chk("model_sub", 32'(out_sub), 32'(m.sub));
            chk("model_rd", 32'(out_rd), 32'(m.rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_use_imm = 0; in_sub = 0;
        in_rs1_idx = 0; in_rs2_idx = 0; in_rd = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
        mem_wr_en = 0; mem_wr_rd = 0; mem_wr_data = 0;
        wb_wr_en = 0; wb_wr_rd = 0; wb_wr_data = 0;
    endtask

    initial begin
        idle();
        out_ready = 1;
        #1 rst = 1;
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_a", out_a, 32'd0);
        chk("reset_b", out_b, 32'd0);
        tick();
        tick();
        rst = 0;

        // Plain add, no hazard.
        in_valid = 1; in_rs1_idx = 1; in_rs1_val = 32'h10;
        in_rs2_idx = 2; in_rs2_val = 32'h5; in_rd = 4;
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_a", out_a, 32'h10);
        chk("add_b", out_b, 32'h5);
        chk("add_sub", 32'(out_sub), 32'd0);
        chk("add_rd", 32'(out_rd), 32'd4);

        // Immediate wins over rs2 and cancels subtract.
        in_use_imm = 1; in_imm = 32'hFFFF_FFFF; in_sub = 1; in_rs2_val = 32'h55;
        tick();
        chk("imm_b", out_b, 32'hFFFF_FFFF);
        chk("imm_sub", 32'(out_sub), 32'd0);

        // MEM beats WB for the same register.
        in_use_imm = 0; in_sub = 0; in_rs1_idx = 3; in_rs1_val = 32'h33;
        mem_wr_en = 1; mem_wr_rd = 3; mem_wr_data = 32'hAA;
        wb_wr_en = 1; wb_wr_rd = 3; wb_wr_data = 32'hBB;
        tick();
        chk("fwd_mem_prio", out_a, FWD_ON ? 32'hAA : 32'h33);

        // x0 never forwards.
        wb_wr_en = 0; in_rs1_idx = 0; in_rs1_val = 0; mem_wr_rd = 0; mem_wr_data = 32'h1;
        tick();
        chk("fwd_x0", out_a, 32'd0);

        // Drain, then hold an entry reading x7 while WB writes x7.
        idle();
        tick();
        out_ready = 0; in_valid = 1; in_rs2_idx = 7; in_rs2_val = 32'h77; in_rd = 9;
        tick();
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_b_init", out_b, 32'h77);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        in_valid = 0; wb_wr_en = 1; wb_wr_rd = 7; wb_wr_data = 32'h1234;
        tick();
        chk("stall_refresh_b", out_b, FWD_ON ? 32'h1234 : 32'h77);
        chk("stall_held_valid", 32'(out_valid), 32'd1);

        // Flush drops the held entry and the offered input.
        idle();
        in_valid = 1; in_rs1_idx = 5; in_rs1_val = 32'hDEAD; flush = 1;
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        idle();
        tick();
        chk("flush_no_capture", 32'(out_valid), 32'd0);

        // Consume and capture on the same edge.
        out_ready = 1; in_valid = 1; in_rs1_idx = 9; in_rs1_val = 32'h111;
        tick();
        chk("cc_first_a", out_a, 32'h111);
        in_rs1_val = 32'h222;
        tick();
        chk("cc_valid", 32'(out_valid), 32'd1);
        chk("cc_second_a", out_a, 32'h222);

        // Asynchronous reset in the middle of a held entry.
        out_ready = 0; in_valid = 0;
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst = 1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_a", out_a, 32'd0);
        tick();
        rst = 0;
        out_ready = 1;

        for (int i = 0; i < 600; i++) begin
            flush      = ($urandom_range(0, 11) == 0);
            in_valid   = $urandom_range(0, 3) != 0;
            out_ready  = $urandom_range(0, 4) < 3;
            in_rs1_idx = 5'($urandom_range(0, 3));
            in_rs2_idx = 5'($urandom_range(0, 3));
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            in_imm     = $urandom;
            in_use_imm = $urandom_range(0, 2) == 0;
            in_sub     = 1'($urandom_range(0, 1));
            in_rd      = 5'($urandom_range(0, 31));
            mem_wr_en  = 1'($urandom_range(0, 1));
            mem_wr_rd  = 5'($urandom_range(0, 3));
            mem_wr_data = $urandom;
            wb_wr_en   = 1'($urandom_range(0, 1));
            wb_wr_rd   = 5'($urandom_range(0, 3));
            wb_wr_data = $urandom;
            tick();
        end

        idle();
        out_ready = 1;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
